// File: rtl/cross_bar_bank_receiver.sv
// rtl/cross_bar_bank_receiver.sv - bank-side cross-bar request receiver: FIFO, fixed-latency service, one-hot completion
module cross_bar_bank_receiver #(
    parameter int CH_NUM     = 3,
    parameter int CH_ID_W    = 2,
    parameter int ENTRY_ID_W = 4,
    parameter int DEPTH      = 4,
    parameter int LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_vld,
    output logic                      req_rdy,
    input  logic [CH_ID_W-1:0]        req_ch_id,
    input  logic [ENTRY_ID_W-1:0]     req_entryID,
    output logic [CH_NUM-1:0]         resp_vld,
    output logic [ENTRY_ID_W-1:0]     resp_entryID,
    input  logic [CH_NUM-1:0]         resp_rdy,
    output logic                      err_illegal_ch,
    output logic [$clog2(DEPTH):0]    fifo_cnt,
    output logic                      busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SVC_W = $clog2(LATENCY + 1);

    localparam logic [CNT_W-1:0]   DEPTH_L   = CNT_W'(DEPTH);
    localparam logic [CH_ID_W:0]   CH_LIMIT  = (CH_ID_W + 1)'(CH_NUM);
    localparam logic [SVC_W-1:0]   SVC_LOAD  = SVC_W'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVICE = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

    logic [CH_ID_W-1:0]    mem_ch [DEPTH];
    logic [ENTRY_ID_W-1:0] mem_id [DEPTH];

    logic [1:0]       state;
    logic [SVC_W-1:0] svc_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic              ch_legal;
    logic              push;
    logic              enq;
    logic              pop;
    logic [CH_NUM-1:0] head_onehot;

    assign fifo_cnt = cnt;
    // Registered count only, so a pop at full never opens the door in the same cycle.
    assign req_rdy  = (cnt < DEPTH_L);
    assign ch_legal = ({1'b0, req_ch_id} < CH_LIMIT);
    assign push     = req_vld && req_rdy;
    assign enq      = push && ch_legal;
    // resp_vld is one-hot on the head channel, so masking ignores other channels' ready.
    assign pop      = (state == ST_RESP) && (|(resp_vld & resp_rdy));
    assign busy     = (state != ST_IDLE) || (cnt != '0);

    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            head_onehot[i] = (CH_ID_W'(i) == mem_ch[rd_ptr]);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_ch[wr_ptr] <= req_ch_id;
            mem_id[wr_ptr] <= req_entryID;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal_ch <= 1'b0;
        end else begin
            err_illegal_ch <= push && !ch_legal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            svc_cnt      <= '0;
            resp_vld     <= '0;
            resp_entryID <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cnt != '0) begin
                        state   <= ST_SERVICE;
                        svc_cnt <= SVC_LOAD;
                    end
                end
                ST_SERVICE: begin
                    if (svc_cnt == '0) begin
                        state        <= ST_RESP;
                        resp_vld     <= head_onehot;
                        resp_entryID <= mem_id[rd_ptr];
                    end else begin
                        svc_cnt <= svc_cnt - SVC_W'(1);
                    end
                end
                ST_RESP: begin
                    if (pop) begin
                        resp_vld <= '0;
                        // Another entry behind the head, or one arriving now, goes straight to service.
                        if ((cnt > CNT_W'(1)) || enq) begin
                            state   <= ST_SERVICE;
                            svc_cnt <= SVC_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cross_bar_bank_receiver.sv
// tb/tb_cross_bar_bank_receiver.sv - scoreboard testbench for cross_bar_bank_receiver
module tb_cross_bar_bank_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_vld;
    logic       req_rdy;
    logic [1:0] req_ch_id;
    logic [3:0] req_entryID;
    logic [2:0] resp_vld;
    logic [3:0] resp_entryID;
    logic [2:0] resp_rdy;
    logic       err_illegal_ch;
    logic [2:0] fifo_cnt;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [5:0] sb[$];
    int         comp_cyc[$];
    logic [3:0] comp_id[$];

    cross_bar_bank_receiver #(
        .CH_NUM(3), .CH_ID_W(2), .ENTRY_ID_W(4), .DEPTH(4), .LATENCY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_ch_id(req_ch_id), .req_entryID(req_entryID),
        .resp_vld(resp_vld), .resp_entryID(resp_entryID), .resp_rdy(resp_rdy),
        .err_illegal_ch(err_illegal_ch), .fifo_cnt(fifo_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (|(resp_vld & resp_rdy))) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {29'd0, resp_vld}, 32'd0);
            end else begin
                logic [5:0] e;
                logic [2:0] oh;
                e  = sb.pop_front();
                oh = 3'b001 << e[5:4];
                check("resp_vld_onehot", {29'd0, resp_vld}, {29'd0, oh});
                check("resp_entryID", {28'd0, resp_entryID}, {28'd0, e[3:0]});
                comp_cyc.push_back(cyc);
                comp_id.push_back(resp_entryID);
            end
        end
    end

    task automatic push_req(input logic [1:0] ch, input logic [3:0] id);
        int n;
        req_vld     = 1'b1;
        req_ch_id   = ch;
        req_entryID = id;
        n = 0;
        while (!req_rdy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        if (ch < 2'd3) sb.push_back({ch, id});
        #1;
        req_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", {31'd0, n < 500}, 32'd1);
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (resp_vld == 3'b000 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_resp", {31'd0, n < 100}, 32'd1);
    endtask

    initial begin
        logic ok;
        rst_n       = 1'b0;
        req_vld     = 1'b0;
        req_ch_id   = 2'd0;
        req_entryID = 4'd0;
        resp_rdy    = 3'b111;
        #1;
        check("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        check("rst_resp_vld", {29'd0, resp_vld}, 32'd0);
        check("rst_entryID", {28'd0, resp_entryID}, 32'd0);
        check("rst_fifo_cnt", {29'd0, fifo_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err_illegal_ch}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single request latency
        push_req(2'd1, 4'h5);
        check("t1_cnt_after_push", {29'd0, fifo_cnt}, 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("t1_no_resp_early", {29'd0, resp_vld}, 32'd0);
        end
        @(posedge clk);
        #1;
        check("t1_resp_vld", {29'd0, resp_vld}, 32'b010);
        check("t1_resp_id", {28'd0, resp_entryID}, 32'h5);
        @(posedge clk);
        #1;
        check("t1_resp_one_cycle", {29'd0, resp_vld}, 32'd0);
        check("t1_cnt_zero", {29'd0, fifo_cnt}, 32'd0);
        check("t1_busy_low", {31'd0, busy}, 32'd0);

        // 2: fill to full with responses blocked, then release
        resp_rdy = 3'b000;
        push_req(2'd0, 4'd1);
        push_req(2'd1, 4'd2);
        push_req(2'd2, 4'd3);
        push_req(2'd0, 4'd4);
        check("t2_full_cnt", {29'd0, fifo_cnt}, 32'd4);
        check("t2_full_rdy", {31'd0, req_rdy}, 32'd0);
        req_vld     = 1'b1;
        req_ch_id   = 2'd1;
        req_entryID = 4'd5;
        repeat (3) @(posedge clk);
        #1;
        check("t2_held_cnt", {29'd0, fifo_cnt}, 32'd4);
        check("t2_held_rdy", {31'd0, req_rdy}, 32'd0);
        resp_rdy = 3'b111;
        push_req(2'd1, 4'd5);
        drain();
        check("t2_total", comp_id.size(), 32'd6);

        // 3: head on channel 2 blocked while other channels are ready
        resp_rdy = 3'b011;
        push_req(2'd2, 4'h9);
        push_req(2'd0, 4'h3);
        wait_resp();
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (resp_vld != 3'b100 || resp_entryID != 4'h9 || fifo_cnt != 3'd2) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check("t3_stable_10", {31'd0, ok}, 32'd1);
        check("t3_vld_hold", {29'd0, resp_vld}, 32'b100);
        resp_rdy = 3'b111;
        @(posedge clk);
        #1;
        check("t3_release_pop", {29'd0, fifo_cnt}, 32'd1);
        drain();

        // 4: illegal channel
        push_req(2'd3, 4'h7);
        check("t4_err_pulse", {31'd0, err_illegal_ch}, 32'd1);
        check("t4_cnt_zero", {29'd0, fifo_cnt}, 32'd0);
        @(posedge clk);
        #1;
        check("t4_err_one_cycle", {31'd0, err_illegal_ch}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("t4_no_resp", {29'd0, resp_vld}, 32'd0);
        check("t4_idle", {31'd0, busy}, 32'd0);

        // 5: continuous traffic with wrap-around
        comp_cyc.delete();
        comp_id.delete();
        for (int i = 0; i < 12; i++) push_req(2'(i % 3), 4'(i));
        drain();
        check("t5_count", comp_id.size(), 32'd12);
        if (comp_id.size() == 12) begin
            for (int i = 1; i < 12; i++) check("t5_spacing", comp_cyc[i] - comp_cyc[i-1], 32'd3);
        end

        // 6: reset in RESP with 3 entries queued
        resp_rdy = 3'b000;
        push_req(2'd0, 4'd1);
        push_req(2'd1, 4'd2);
        push_req(2'd2, 4'd3);
        wait_resp();
        check("t6_cnt_before", {29'd0, fifo_cnt}, 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", {29'd0, resp_vld}, 32'd0);
        check("t6_rst_cnt", {29'd0, fifo_cnt}, 32'd0);
        check("t6_rst_rdy", {31'd0, req_rdy}, 32'd1);
        sb.delete();
        comp_id.delete();
        comp_cyc.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        resp_rdy = 3'b111;
        push_req(2'd1, 4'hA);
        drain();
        check("t6_post_count", comp_id.size(), 32'd1);
        if (comp_id.size() != 0) check("t6_first_id", {28'd0, comp_id[0]}, 32'hA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cross_bar_bank_receiver.md
Name: cross_bar_bank_receiver

Overview:
- Bank-side endpoint of the cross-bar request path. One instance per bank.
- Accepts granted requests (originating channel ID and entry ID) from the cross-bar core and queues them in a FIFO.
- Services queued requests in order with a fixed service latency.
- Returns a completion carrying the entry ID to the originating channel buffer, so that channel can retire the entry.

Parameters:
- CH_NUM, 3, number of cross-bar channels; a channel ID is legal when it is less than CH_NUM.
- CH_ID_W, 2, width of the channel ID field.
- ENTRY_ID_W, 4, width of the channel-buffer entry ID.
- DEPTH, 4, FIFO depth in entries; must be a power of 2 and at least 2.
- LATENCY, 2, service cycles per request; must be at least 1.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_vld, input, 1, granted request from the cross-bar core is valid.
- req_rdy, output, 1, receiver can accept a request.
- req_ch_id, input, CH_ID_W, channel that issued the request.
- req_entryID, input, ENTRY_ID_W, entry ID in the originating channel buffer.
- resp_vld, output, CH_NUM, one-hot completion valid, indexed by the originating channel.
- resp_entryID, output, ENTRY_ID_W, entry ID being completed.
- resp_rdy, input, CH_NUM, per-channel completion ready.
- err_illegal_ch, output, 1, one-cycle pulse when a request with an illegal channel ID is accepted.
- fifo_cnt, output, $clog2(DEPTH)+1, number of queued entries, including the one in service.
- busy, output, 1, state is not IDLE or fifo_cnt is non-zero.

Behaviour:
Reset
- While rst_n is low, immediately (asynchronously): FIFO pointers and count = 0, state = IDLE, service counter = 0.
- Outputs under reset: resp_vld = 0, resp_entryID = 0, err_illegal_ch = 0, busy = 0, req_rdy = 1.
- Reset mid-operation discards all queued and in-flight entries. No completion is produced for them.

Accept
- req_rdy = (fifo_cnt < DEPTH).
- req_rdy is driven from registered count only and never depends on req_vld.
- A push occurs when req_vld && req_rdy at a rising edge.
- When full, req_rdy = 0 even if a pop happens in the same cycle. No push/pop bypass at full.
- If req_ch_id >= CH_NUM on a push:
  - the request is consumed but not enqueued;
  - err_illegal_ch is 1 for the following cycle.
- Pointers wrap modulo DEPTH.

Push and pop in the same edge (not full)
- fifo_cnt is unchanged.
- The write pointer and read pointer both advance.

FSM (states IDLE, SERVICE, RESP)
- IDLE:
  - goes to SERVICE when fifo_cnt != 0;
  - on entry to SERVICE, the service counter is loaded with LATENCY-1.
- SERVICE:
  - the counter decrements each cycle;
  - at counter = 0 the next state is RESP.
- RESP:
  - resp_vld[head.ch_id] = 1 and resp_entryID = head.entryID, both registered;
  - all other resp_vld bits are 0;
  - resp_vld and resp_entryID stay stable until resp_rdy[head.ch_id] = 1;
  - resp_rdy bits of other channels are ignored.
- On the RESP handshake:
  - the head entry is popped;
  - if fifo_cnt > 1 before the pop, or a push happens on the same edge, go to SERVICE (counter = LATENCY-1);
  - otherwise go to IDLE.
- resp_vld deasserts on the handshake edge unless the next state is RESP, which is impossible because LATENCY >= 1.

Timing and ordering
- Latency: a request pushed into an empty receiver at edge T raises resp_vld after edge T+LATENCY+1, given that resp_rdy is held high.
- Steady-state throughput: one completion per LATENCY+1 cycles.
- Completions are returned in strict acceptance order, across all channels.
- No arithmetic on IDs; they pass through unchanged.

Test Plan:
1. Reset, then a single request with ch_id = 1, entryID = 0x5, LATENCY = 2, resp_rdy = 3'b111.
   -> resp_vld = 3'b010 and resp_entryID = 0x5 after edge T+3, for exactly one cycle. fifo_cnt goes 1 -> 0; busy then falls.
2. Push 5 requests back-to-back (ch 0,1,2,0,1; IDs 1..5) with resp_rdy = 0.
   -> req_rdy drops after the 4th push and the 5th is held; fifo_cnt = 4.
   -> On release, completions arrive in order 1,2,3,4,5, with one-hot resp_vld 001, 010, 100, 001, 010.
3. Hold resp_rdy[2] = 0 with resp_rdy[0] = resp_rdy[1] = 1 while the head entry is ch 2, ID 0x9.
   -> resp_vld stays 3'b100 and resp_entryID stays 0x9, stable for 10 cycles.
   -> The next entry starts SERVICE only after resp_rdy[2] rises.
4. Request with ch_id = 3 (CH_NUM = 3), ID 0x7.
   -> err_illegal_ch pulses for 1 cycle; fifo_cnt stays 0; no resp_vld ever.
5. Continuous traffic with wrap-around: 12 requests with IDs 0..11 and resp_rdy = 1.
   -> All 12 complete in order; completions are spaced LATENCY+1 = 3 cycles apart; pointers wrap 3 times with no loss.
6. Assert rst_n = 0 while in RESP with 3 entries queued.
   -> resp_vld = 0 immediately; fifo_cnt = 0; req_rdy = 1.
   -> After reset release, a new request ID 0xA is the first completion.
